// File: rtl/simmem_pkg.sv
// Shared types for the simulated-memory delay releaser: ID, delay and slot record.
package simmem_pkg;

   localparam int unsigned DefIDWidth    = 8;
   localparam int unsigned DefDelayWidth = 8;
   localparam int unsigned DefNumSlots   = 16;

   typedef logic [DefIDWidth-1:0]    id_t;
   typedef logic [DefDelayWidth-1:0] delay_t;

   typedef struct packed {
      logic   valid;
      id_t    id;
      delay_t counter;
   } slot_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One delay entry: loads an ID and a delay, counts down to zero and holds,
// reports expiry, and empties on a free strobe.
module simmem_delay_slot
   import simmem_pkg::*;
#(
   parameter int unsigned IDWidth    = DefIDWidth,
   parameter int unsigned DelayWidth = DefDelayWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [IDWidth-1:0]    id_i,
   input  logic [DelayWidth-1:0] delay_i,
   input  logic                  free_i,
   output logic                  valid_o,
   output logic [IDWidth-1:0]    id_o,
   output logic                  expired_o
);

   logic                  valid_q, valid_d;
   logic [IDWidth-1:0]    id_q, id_d;
   logic [DelayWidth-1:0] cnt_q, cnt_d;

   always_comb begin
      valid_d = valid_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      // Counter saturates at zero so an expired entry stays expired until freed.
      if (valid_q && (cnt_q != '0)) cnt_d = cnt_q - DelayWidth'(1);
      if (load_i) begin
         valid_d = 1'b1;
         id_d    = id_i;
         cnt_d   = delay_i;
      end
      if (free_i) valid_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_o   = valid_q;
   assign id_o      = id_q;
   assign expired_o = valid_q && (cnt_q == '0);

endmodule

// File: rtl/simmem_delay_releaser.sv
// Holds delayed message IDs in a slot pool and raises per-ID release enables on expiry.
// Define SIMMEM_DELAY_RELEASER_ASSERT_EN to compile in protocol assertions.
module simmem_delay_releaser
   import simmem_pkg::*;
#(
   parameter int unsigned IDWidth    = DefIDWidth,
   parameter int unsigned NumSlots   = DefNumSlots,
   parameter int unsigned DelayWidth = DefDelayWidth
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [IDWidth-1:0]       in_id_i,
   input  logic [DelayWidth-1:0]    in_delay_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   output logic [(2**IDWidth)-1:0]  release_en_o,
   input  logic [(2**IDWidth)-1:0]  release_done_i
);

   logic [NumSlots-1:0]              slot_valid;
   logic [NumSlots-1:0]              slot_exp;
   logic [NumSlots-1:0]              slot_load;
   logic [NumSlots-1:0]              slot_free;
   logic [NumSlots-1:0][IDWidth-1:0] slot_id;

   for (genvar s = 0; s < NumSlots; s++) begin : g_slot
      simmem_delay_slot #(
         .IDWidth   (IDWidth),
         .DelayWidth(DelayWidth)
      ) u_slot (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .load_i   (slot_load[s]),
         .id_i     (in_id_i),
         .delay_i  (in_delay_i),
         .free_i   (slot_free[s]),
         .valid_o  (slot_valid[s]),
         .id_o     (slot_id[s]),
         .expired_o(slot_exp[s])
      );
   end

   // Ready looks only at registered valids, so a slot freed this cycle is not reused until next.
   assign in_ready_o = ~&slot_valid;

   always_comb begin
      logic found;
      found     = 1'b0;
      slot_load = '0;
      for (int s = 0; s < NumSlots; s++) begin
         if (!found && !slot_valid[s]) begin
            slot_load[s] = in_valid_i;
            found        = 1'b1;
         end
      end
   end

   // Each done bit frees only the lowest-index expired slot carrying that ID.
   always_comb begin
      slot_free = '0;
      for (int s = 0; s < NumSlots; s++) begin
         slot_free[s] = slot_exp[s] && release_done_i[slot_id[s]];
         for (int j = 0; j < s; j++) begin
            if (slot_exp[j] && (slot_id[j] == slot_id[s])) slot_free[s] = 1'b0;
         end
      end
   end

   always_comb begin
      release_en_o = '0;
      for (int s = 0; s < NumSlots; s++) begin
         if (slot_exp[s]) release_en_o[slot_id[s]] = 1'b1;
      end
   end

`ifdef SIMMEM_DELAY_RELEASER_ASSERT_EN
   logic stall_q;

   always_ff @(posedge clk_i) begin
      stall_q <= rst_ni && in_valid_i && !in_ready_o;
      if (!rst_ni) begin
         a_done_in_reset: assert (release_done_i == '0);
      end else begin
         a_done_no_expired: assert ((release_done_i & ~release_en_o) == '0);
         if (stall_q) begin
            a_valid_held: assert (in_valid_i);
         end
      end
   end
`else
   // No checking logic in the default build.
`endif

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Scoreboard bench for simmem_delay_releaser: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_simmem_delay_releaser;

   localparam int IDW = 8;
   localparam int NS  = 16;
   localparam int DW  = 8;
   localparam int NID = 1 << IDW;

   logic           clk = 1'b0;
   logic           rst_ni = 1'b0;
   logic [IDW-1:0] in_id = '0;
   logic [DW-1:0]  in_delay = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [NID-1:0] release_en;
   logic [NID-1:0] release_done = '0;

   simmem_delay_releaser #(.IDWidth(IDW), .NumSlots(NS), .DelayWidth(DW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .in_id_i       (in_id),
      .in_delay_i    (in_delay),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .release_en_o  (release_en),
      .release_done_i(release_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind 0: release_en bit idx; kind 1: in_ready; kind 2: OR of all release_en
   typedef struct {
      int    c;
      int    kind;
      int    idx;
      int    val;
      string name;
   } exp_t;

   exp_t q[$];
   int errors = 0;
   int checks = 0;

   task automatic expect_at(input int c, input int kind, input int idx, input int val, input string name);
      exp_t e;
      e.c = c; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      int act;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].c == cyc) begin
            case (q[i].kind)
               0:       act = int'(release_en[q[i].idx]);
               1:       act = int'(in_ready);
               default: act = int'(|release_en);
            endcase
            checks++;
            if (act != q[i].val) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%0d want=%0d", q[i].name, cyc, act, q[i].val);
            end
            q.delete(i);
         end else if (q[i].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missed at cyc=%0d", q[i].name, q[i].c);
            q.delete(i);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic issue(input int id, input int d);
      in_valid = 1'b1;
      in_id    = IDW'(id);
      in_delay = DW'(d);
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      int t;
      // Reset with garbage on the inputs; it must not be captured.
      in_valid = 1'b1; in_id = 8'd5; in_delay = 8'd0;
      step(3);
      rst_ni = 1'b1; in_valid = 1'b0;
      expect_at(cyc, 1, 0, 1, "rst_ready");
      expect_at(cyc, 2, 0, 0, "rst_en_zero");
      expect_at(cyc + 1, 0, 5, 0, "rst_input_ignored");
      step(2);

      // id=3 delay=5: rises at t+6, cleared by done at t+6
      t = cyc;
      expect_at(t + 5, 0, 3, 0, "A_pre");
      expect_at(t + 6, 0, 3, 1, "A_rise");
      expect_at(t + 7, 0, 3, 0, "A_fall");
      issue(3, 5);
      wait_until(t + 6);
      release_done[3] = 1'b1; step(); release_done = '0;
      step(2);

      // id=7 delay=0: high the very next cycle
      t = cyc;
      expect_at(t + 1, 0, 7, 1, "B_zero_delay");
      expect_at(t + 2, 0, 7, 0, "B_fall");
      issue(7, 0);
      release_done[7] = 1'b1; step(); release_done = '0;
      step(2);

      // two id=2 entries: bit held until both freed
      t = cyc;
      expect_at(t + 3, 0, 2, 0, "C_pre");
      expect_at(t + 4, 0, 2, 1, "C_first");
      expect_at(t + 6, 0, 2, 1, "C_both");
      expect_at(t + 7, 0, 2, 1, "C_after_one_done");
      expect_at(t + 8, 0, 2, 0, "C_after_two_done");
      issue(2, 3);
      issue(2, 4);
      wait_until(t + 6);
      release_done[2] = 1'b1; step(2); release_done = '0;
      step(2);

      // stray done[9] must not free the expired id=4 entry
      t = cyc;
      expect_at(t + 1, 0, 4, 1, "D_expired");
      expect_at(t + 2, 0, 4, 1, "D_spurious_keep");
      expect_at(t + 2, 0, 9, 0, "D_no_id9");
      expect_at(t + 2, 1, 0, 1, "D_ready");
      expect_at(t + 3, 2, 0, 0, "D_cleared");
      issue(4, 0);
      release_done[9] = 1'b1; step(); release_done = '0;
      release_done[4] = 1'b1; step(); release_done = '0;
      step(2);

      // two done bits in one cycle free both IDs
      t = cyc;
      expect_at(t + 2, 0, 10, 1, "E_id10");
      expect_at(t + 2, 0, 11, 1, "E_id11");
      expect_at(t + 3, 2, 0, 0, "E_both_freed");
      issue(10, 0);
      issue(11, 0);
      release_done[10] = 1'b1; release_done[11] = 1'b1; step(); release_done = '0;
      step(2);

      // fill all 16 slots, then free one on first expiry
      t = cyc;
      expect_at(t + 15, 1, 0, 1, "F_ready_before_16th");
      expect_at(t + 16, 1, 0, 0, "F_full");
      expect_at(t + 30, 0, 8'h99, 0, "F_full_ignores_input");
      expect_at(t + 200, 0, 8'h40, 0, "F_not_yet");
      expect_at(t + 201, 0, 8'h40, 1, "F_first_expiry");
      expect_at(t + 201, 1, 0, 0, "F_no_same_cycle_ready");
      expect_at(t + 202, 1, 0, 1, "F_ready_next_cycle");
      expect_at(t + 202, 0, 8'h40, 0, "F_freed");
      expect_at(t + 202, 0, 8'h99, 0, "F_no_early_realloc");
      expect_at(t + 203, 0, 8'h99, 1, "F_realloc");
      expect_at(t + 203, 1, 0, 0, "F_full_again");
      for (int i = 0; i < NS; i++) issue(8'h40 + i, 200);
      in_valid = 1'b1; in_id = 8'h99; in_delay = 8'd0;
      wait_until(t + 201);
      release_done[8'h40] = 1'b1; step(); release_done = '0;
      step();
      in_valid = 1'b0;
      step();

      // reset with a full, partly expired pool
      t = cyc;
      expect_at(t + 1, 1, 0, 1, "G_rst_ready");
      expect_at(t + 1, 2, 0, 0, "G_rst_en_zero");
      rst_ni = 1'b0; step(); rst_ni = 1'b1;
      step(2);

      // reset while 4 entries count down
      t = cyc;
      expect_at(t + 10, 1, 0, 1, "H_rst_ready");
      expect_at(t + 10, 2, 0, 0, "H_rst_en_zero");
      expect_at(t + 45, 2, 0, 0, "H_counters_cleared");
      for (int i = 0; i < 4; i++) issue(20 + i, 30 + i);
      step(5);
      rst_ni = 1'b0; step(); rst_ni = 1'b1;
      wait_until(t + 46);
      step(2);

      foreach (q[i]) begin
         checks++;
         errors++;
         $display("FAIL %s never checked (cyc=%0d)", q[i].name, q[i].c);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
